// File: rtl/sysid_timer_regs.sv
// System identification slave: ID/timestamp/version words, scratch register,
// 64-bit uptime counter with atomic high-word capture, seconds counter and control.
module sysid_timer_regs #(
    parameter logic [31:0] SYSTEM_ID     = 32'h0400_0000,
    parameter logic [31:0] TIMESTAMP     = 32'd0,
    parameter logic [31:0] VERSION       = 32'h0001_0000,
    parameter int unsigned CLOCK_FREQ    = 50_000_000,
    parameter logic [31:0] SCRATCH_RESET = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [2:0]  address,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        readdatavalid
);

    localparam logic [31:0] PRESC_LAST = 32'(CLOCK_FREQ - 1);

    logic [31:0] scratch_q, scratch_d;
    logic [63:0] uptime_q, uptime_d;
    logic [31:0] hi_shadow_q, hi_shadow_d;
    logic [31:0] presc_q, presc_d;
    logic [31:0] seconds_q, seconds_d;
    logic        freeze_q, freeze_d;
    logic [31:0] readdata_q, readdata_d;
    logic        readdatavalid_q;

    logic wr_en;
    logic clear;
    logic rd_lo;

    // A simultaneous read wins; the write is dropped entirely.
    assign wr_en = write & ~read;
    assign clear = wr_en && (address == 3'd7) && writedata[0];
    assign rd_lo = read && (address == 3'd4);

    always_comb begin
        readdata_d = readdata_q;
        if (read) begin
            case (address)
                3'd0:    readdata_d = SYSTEM_ID;
                3'd1:    readdata_d = TIMESTAMP;
                3'd2:    readdata_d = VERSION;
                3'd3:    readdata_d = scratch_q;
                3'd4:    readdata_d = uptime_q[31:0];
                3'd5:    readdata_d = hi_shadow_q;
                3'd6:    readdata_d = seconds_q;
                default: readdata_d = {30'd0, freeze_q, 1'b0};
            endcase
        end
    end

    always_comb begin
        scratch_d   = scratch_q;
        freeze_d    = freeze_q;
        uptime_d    = uptime_q;
        hi_shadow_d = hi_shadow_q;
        presc_d     = presc_q;
        seconds_d   = seconds_q;

        if (wr_en && (address == 3'd3)) begin
            scratch_d = writedata;
        end
        if (wr_en && (address == 3'd7)) begin
            freeze_d = writedata[1];
        end

        if (!freeze_q) begin
            uptime_d = uptime_q + 64'd1;
            if (presc_q == PRESC_LAST) begin
                presc_d   = 32'd0;
                seconds_d = seconds_q + 32'd1;
            end else begin
                presc_d = presc_q + 32'd1;
            end
        end

        // Capture the high word in the same edge as the low-word read.
        if (rd_lo) begin
            hi_shadow_d = uptime_q[63:32];
        end

        if (clear) begin
            uptime_d    = 64'd0;
            hi_shadow_d = 32'd0;
            presc_d     = 32'd0;
            seconds_d   = 32'd0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            scratch_q       <= SCRATCH_RESET;
            uptime_q        <= 64'd0;
            hi_shadow_q     <= 32'd0;
            presc_q         <= 32'd0;
            seconds_q       <= 32'd0;
            freeze_q        <= 1'b0;
            readdata_q      <= 32'd0;
            readdatavalid_q <= 1'b0;
        end else begin
            scratch_q       <= scratch_d;
            uptime_q        <= uptime_d;
            hi_shadow_q     <= hi_shadow_d;
            presc_q         <= presc_d;
            seconds_q       <= seconds_d;
            freeze_q        <= freeze_d;
            readdata_q      <= readdata_d;
            readdatavalid_q <= read;
        end
    end

    assign readdata      = readdata_q;
    assign readdatavalid = readdatavalid_q;

endmodule

// File: doc/sysid_timer_regs.md
Name: sysid_timer_regs

Overview:
- Parametrised Avalon-MM slave for system identification, the next generation of the two-word read-only sysid block.
- Exposes the ID and build timestamp, plus:
  - a version/feature word;
  - a writable scratch register;
  - a 64-bit free-running uptime cycle counter with atomic high-word capture;
  - a seconds counter;
  - a control register.
- Sits on the Qsys/Platform Designer interconnect beside the stepper control peripherals. Software uses it for build checks and time-stamping.

Parameters:
- SYSTEM_ID, 32'h0400_0000, value returned at word 0.
- TIMESTAMP, 32'd0, build timestamp (Unix seconds) returned at word 1.
- VERSION, 32'h0001_0000, version/feature word returned at word 2.
- CLOCK_FREQ, 50_000_000, clock cycles per second for the seconds prescaler. Legal range is ≥2.
- SCRATCH_RESET, 32'h0000_0000, reset value of the scratch register.

Ports:
- clock  in  1  system clock; all logic is rising-edge.
- reset_n  in  1  asynchronous, active-low reset.
- address  in  3  word address.
- read  in  1  read strobe.
- write  in  1  write strobe.
- writedata  in  32  write data.
- readdata  out  32  registered read data.
- readdatavalid  out  1  high for one cycle, one clock after an accepted read.

Behaviour:
- Reset state (async assert, sync release), applied to every storage element: readdata=0, readdatavalid=0, scratch=SCRATCH_RESET, uptime=0, hi_shadow=0, prescaler=0, seconds=0, freeze=0.
- Register map (word address):
  - 0 ID, RO
  - 1 TIMESTAMP, RO
  - 2 VERSION, RO
  - 3 SCRATCH, RW
  - 4 UPTIME_LO, RO
  - 5 UPTIME_HI (shadow), RO
  - 6 SECONDS, RO
  - 7 CONTROL
- CONTROL register:
  - bit0 CLEAR is write-1 pulse, reads 0.
  - bit1 FREEZE is RW.
  - Bits 31:2 read 0.
- No waitrequest; every access is accepted in the cycle it is presented.
- Read latency is fixed at 1:
  - read in cycle N makes readdata/readdatavalid valid in N+1.
  - Back-to-back reads are supported every cycle.
  - readdata holds its last value when readdatavalid=0.
- read and write both high in the same cycle: the read is serviced and the write is ignored.
- Writes to RO addresses (0,1,2,4,5,6) are ignored and have no side effects.
- Uptime counter, 64-bit:
  - Increments by 1 every cycle unless FREEZE=1.
  - Wraps from 2^64-1 to 0.
- Atomic 64-bit read:
  - A read of address 4 returns uptime[31:0] as of cycle N.
  - In the same edge it loads hi_shadow with uptime[63:32] from the same cycle.
  - Address 5 returns hi_shadow, which changes only on an address-4 read, reset, or CLEAR.
- Seconds counter:
  - The prescaler counts 0..CLOCK_FREQ-1.
  - At terminal count the prescaler returns to 0 and seconds increments.
  - seconds is 32-bit and wraps to 0.
  - FREEZE=1 halts both prescaler and seconds.
- CLEAR:
  - A write to address 7 with writedata[0]=1 zeroes uptime, hi_shadow, prescaler and seconds at that edge.
  - CLEAR overrides any increment in the same cycle.
  - FREEZE is updated from writedata[1] in the same write.
  - If FREEZE=0 afterwards, counting resumes from 0 on the next cycle.
- A reset mid-operation aborts any pending readdatavalid, which is forced to 0 immediately.

Test Plan:
- Release reset, then read addresses 0,1,2 back-to-back → readdatavalid is high 3 consecutive cycles with readdata = 0x04000000, TIMESTAMP, 0x00010000. During reset all outputs are 0.
- Write 0xDEADBEEF to address 3, read it back → 0xDEADBEEF. Write 0x12345678 to address 0, then read address 0 → still 0x04000000. Assert reset → scratch reads SCRATCH_RESET.
- Force uptime to 0x0000_0000_FFFF_FFFE and read address 4 in cycle N → LO=0xFFFFFFFE. A later read of address 5 → 0x00000000, even though the live counter has carried to 1.
- With CLOCK_FREQ=4, run 10 cycles after reset → seconds reads 2. Write CONTROL=0x2 (freeze), wait 20 cycles → seconds and UPTIME_LO are unchanged.
- With uptime nonzero, write CONTROL=0x1 → the next UPTIME_LO read returns 1 (or the expected small count) and seconds reads 0. Read CONTROL → 0x0.
- Assert read and write together at address 3 with writedata=0xA5A5A5A5 → the read returns the old scratch and scratch is unchanged. Assert reset in the cycle after a read → readdatavalid drops to 0 immediately.
